// File: rtl/oam_dma_pkg.sv
// Shared video/memory constants and the OAM DMA state encoding.
package oam_dma_pkg;

  localparam logic [15:0] OAM_LOC      = 16'hFE00;
  localparam int unsigned OAM_SIZE     = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_RD,
    DMA_CAP,
    DMA_WR
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies XFER_LEN bytes from {page,8'h00} into OAM on a write to DMA_REG_ADDR.
// Define OAM_DMA_RESTART_EN to let a register write during a transfer restart it with the new page.
module oam_dma #(
  parameter logic [15:0] OAM_BASE     = oam_dma_pkg::OAM_LOC,
  parameter int unsigned XFER_LEN     = oam_dma_pkg::OAM_SIZE,
  parameter logic [15:0] DMA_REG_ADDR = oam_dma_pkg::DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_wr,
  input  logic        s_rd,
  input  logic [15:0] s_addr,
  input  logic [7:0]  s_wdata,
  output logic [7:0]  s_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic        m_gnt,
  input  logic [7:0]  m_rdata,
  output logic        busy,
  output logic        done
);
  import oam_dma_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_m_req;
  logic        r_m_we;
  logic [15:0] r_m_addr;
  logic        r_done;

  logic        w_sel_wr;
  logic        w_start;
  logic [7:0]  w_idx_nxt;

  // Pages in echo RAM (E0..FF) alias the work RAM 0x2000 below.
  function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [7:0] idx);
    logic [7:0] p;
    p = (page >= 8'hE0) ? (page - 8'h20) : page;
    return {p, idx};
  endfunction

  assign w_sel_wr  = s_wr && (s_addr == DMA_REG_ADDR);
  assign w_idx_nxt = r_idx + 8'd1;

`ifdef OAM_DMA_RESTART_EN
  assign w_start = w_sel_wr;
`else
  assign w_start = w_sel_wr && (r_state == DMA_IDLE);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= DMA_IDLE;
      r_page   <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_m_req  <= 1'b0;
      r_m_we   <= 1'b0;
      r_m_addr <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A start (or restart) overrides whatever the FSM would do; a granted access this cycle has already completed on the bus.
      if (w_start) begin
        r_page   <= s_wdata;
        r_idx    <= '0;
        r_m_req  <= 1'b1;
        r_m_we   <= 1'b0;
        r_m_addr <= src_addr(s_wdata, 8'h00);
        r_state  <= DMA_RD;
      end else begin
        unique case (r_state)
          DMA_IDLE: ;
          DMA_RD: begin
            if (m_gnt) begin
              r_m_req <= 1'b0;
              r_state <= DMA_CAP;
            end
          end
          DMA_CAP: begin
            r_data   <= m_rdata;
            r_m_req  <= 1'b1;
            r_m_we   <= 1'b1;
            r_m_addr <= OAM_BASE + {8'h00, r_idx};
            r_state  <= DMA_WR;
          end
          DMA_WR: begin
            if (m_gnt) begin
              r_m_we <= 1'b0;
              if (r_idx == LAST_IDX) begin
                r_m_req <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DMA_IDLE;
              end else begin
                r_idx    <= w_idx_nxt;
                r_m_req  <= 1'b1;
                r_m_addr <= src_addr(r_page, w_idx_nxt);
                r_state  <= DMA_RD;
              end
            end
          end
          default: r_state <= DMA_IDLE;
        endcase
      end
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_data;
  assign busy    = (r_state != DMA_IDLE);
  assign done    = r_done;
  assign s_rdata = (s_rd && (s_addr == DMA_REG_ADDR)) ? r_page : '0;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a transaction-level model predicts every bus access and status output.
`timescale 1ns/1ps
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_wr = 1'b0;
  logic        s_rd = 1'b0;
  logic [15:0] s_addr = '0;
  logic [7:0]  s_wdata = '0;
  logic [7:0]  s_rdata;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_gnt = 1'b0;
  logic [7:0]  m_rdata = '0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_wr    (s_wr),
    .s_rd    (s_rd),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_rdata (m_rdata),
    .busy    (busy),
    .done    (done)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: a transfer is the list of 320 accesses (read src i, write FE00+i) for i = 0..159.
  bit          m_active = 0;
  logic [7:0]  m_page = '0;
  logic [7:0]  exp_page = '0;
  int unsigned k = 0;
  bit          exp_done = 0;
  bit          capture = 0;
  bit          stall_chk = 0;
  logic [15:0] st_addr;
  logic        st_we;
  logic [7:0]  st_wdata;
  bit          rd_pending = 0;
  logic [15:0] rd_addr = '0;
  int unsigned gnt_pct = 100;
  bit          wr_req = 0;
  logic [7:0]  wr_page = '0;
  int          cyc = 0;
  int          first_req_cyc = -1;
  int          done_cyc = 0;
  int unsigned n_done = 0;
  int unsigned n_writes = 0;
  logic [15:0] first_rd = '0;
  logic [15:0] last_rd = '0;
  logic [7:0]  first_wd = '0;
  bit          first_rd_seen = 0;
  bit          first_wd_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  function automatic logic [15:0] exp_src(input logic [7:0] pg, input int unsigned b);
    logic [7:0] sp;
    sp = (pg >= 8'hE0) ? pg - 8'h20 : pg;
    return {sp, 8'(b)};
  endfunction

  task automatic start(input logic [7:0] pg);
    m_active      = 1;
    m_page        = pg;
    exp_page      = pg;
    k             = 0;
    capture       = 0;
    stall_chk     = 0;
    n_writes      = 0;
    first_req_cyc = -1;
    first_rd_seen = 0;
    first_wd_seen = 0;
  endtask

  task automatic model_reset();
    m_active   = 0;
    exp_page   = '0;
    capture    = 0;
    stall_chk  = 0;
    exp_done   = 0;
    rd_pending = 0;
    wr_req     = 0;
  endtask

  // One clock: check outputs, drive inputs, then advance the model over the coming edge.
  task automatic cycle();
    logic [15:0] ea;
    int unsigned b;
    bit was_active;
    @(negedge clk);
    cyc++;
    chk("busy", busy, m_active);
    chk("done", done, exp_done);
    chk("m_req", m_req, m_active && !capture);
    if (stall_chk) begin
      chk("hold_addr", m_addr, st_addr);
      chk("hold_we", m_we, st_we);
      chk("hold_wdata", m_wdata, st_wdata);
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (m_req && m_active && first_req_cyc < 0) first_req_cyc = cyc;

    m_gnt   = ($urandom_range(0, 99) < gnt_pct);
    m_rdata = rd_pending ? mem(rd_addr) : 8'($urandom);
    if (wr_req) begin
      s_addr  = 16'hFF46;
      s_wr    = 1'b1;
      s_wdata = wr_page;
      wr_req  = 0;
    end else begin
      s_addr  = $urandom_range(0, 1) ? 16'hFF46 : 16'($urandom);
      s_wr    = (s_addr != 16'hFF46) && ($urandom_range(0, 1) == 1);
      s_wdata = 8'($urandom);
    end
    s_rd = ($urandom_range(0, 1) == 1);
    #1;
    chk("s_rdata", s_rdata, (s_rd && s_addr == 16'hFF46) ? exp_page : 8'h00);

    rd_pending = 0;
    exp_done   = 0;
    was_active = m_active;
    stall_chk  = m_req && !m_gnt;
    st_addr    = m_addr;
    st_we      = m_we;
    st_wdata   = m_wdata;
    capture    = 0;
    if (m_req && m_gnt && m_active) begin
      b  = k / 2;
      ea = exp_src(m_page, b);
      if (k % 2 == 0) begin
        chk("rd_we", m_we, 0);
        chk("rd_addr", m_addr, ea);
        rd_pending = 1;
        rd_addr    = m_addr;
        capture    = 1;
        if (!first_rd_seen) begin first_rd = m_addr; first_rd_seen = 1; end
        last_rd = m_addr;
      end else begin
        chk("wr_we", m_we, 1);
        chk("wr_addr", m_addr, 16'hFE00 + 16'(b));
        chk("wr_data", m_wdata, mem(ea));
        n_writes++;
        if (!first_wd_seen) begin first_wd = m_wdata; first_wd_seen = 1; end
      end
      k++;
      if (k == 320) begin m_active = 0; exp_done = 1; end
    end
    if (s_wr && s_addr == 16'hFF46) begin
      if (!was_active) start(s_wdata);
`ifdef OAM_DMA_RESTART_EN
      else begin start(s_wdata); exp_done = 0; end
`endif
    end
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (n_done == 0 && n < budget) begin cycle(); n++; end
    chk("done_within_budget", n_done != 0, 1);
    repeat (3) cycle();
  endtask

  task automatic run_xfer(input logic [7:0] pg, input int unsigned pct, input int unsigned budget);
    gnt_pct = pct;
    n_done  = 0;
    wr_req  = 1;
    wr_page = pg;
    cycle();
    wait_done(budget);
  endtask

  task automatic readback(input string name, input logic [15:0] a, input logic [7:0] exp);
    s_wr   = 1'b0;
    s_rd   = 1'b1;
    s_addr = a;
    #1;
    chk(name, s_rdata, exp);
  endtask

  initial begin
    logic [7:0] pg;
    int unsigned n;
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (3) cycle();
    readback("rb_after_reset", 16'hFF46, 8'h00);
    readback("rb_unselected", 16'hFF47, 8'h00);

    // Full transfer with grant tied high.
    run_xfer(8'hC1, 100, 600);
    chk("c1_done_count", n_done, 1);
    chk("c1_req_to_done", 32'(done_cyc - first_req_cyc), 480);
    chk("c1_writes", n_writes, 160);
    chk("c1_first_rd", first_rd, 16'hC100);
    chk("c1_first_wd", first_wd, 8'h5A);
    readback("c1_readback", 16'hFF46, 8'hC1);

    // Echo RAM page.
    run_xfer(8'hE3, 100, 600);
    chk("e3_first_rd", first_rd, 16'hC300);
    chk("e3_last_rd", last_rd, 16'hC39F);
    chk("e3_done_count", n_done, 1);

    // Mostly withheld grant.
    run_xfer(8'h42, 25, 5000);
    chk("slow_writes", n_writes, 160);
    chk("slow_done_count", n_done, 1);

    // Second register write at byte 50.
    gnt_pct = 60; n_done = 0; wr_req = 1; wr_page = 8'hC1;
    cycle();
    n = 0;
    while (k < 100 && n < 2000) begin cycle(); n++; end
    chk("byte50_reached", k >= 100, 1);
    wr_req = 1; wr_page = 8'hD0;
    wait_done(4000);
    chk("rs_done_count", n_done, 1);
    chk("rs_writes", n_writes, 160);
`ifdef OAM_DMA_RESTART_EN
    chk("rs_first_rd", first_rd, 16'hD000);
    readback("rs_readback", 16'hFF46, 8'hD0);
`else
    chk("rs_first_rd", first_rd, 16'hC100);
    chk("rs_last_rd", last_rd, 16'hC19F);
    readback("rs_readback", 16'hFF46, 8'hC1);
`endif

    // Reset at byte 80.
    gnt_pct = 70; n_done = 0; wr_req = 1; wr_page = 8'($urandom);
    cycle();
    n = 0;
    while (k < 160 && n < 2000) begin cycle(); n++; end
    chk("byte80_reached", k >= 160, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_m_req", m_req, 0);
    chk("arst_m_we", m_we, 0);
    chk("arst_m_addr", m_addr, 0);
    chk("arst_m_wdata", m_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (10) cycle();
    chk("arst_no_done", n_done, 0);
    readback("arst_readback", 16'hFF46, 8'h00);
    run_xfer(8'($urandom), 50, 4000);
    chk("post_rst_done_count", n_done, 1);
    chk("post_rst_writes", n_writes, 160);

    // A few fully random transfers.
    for (int i = 0; i < 3; i++) begin
      pg = 8'($urandom);
      run_xfer(pg, $urandom_range(30, 100), 5000);
      chk("rand_done_count", n_done, 1);
      readback("rand_readback", 16'hFF46, pg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine that sits directly upstream of the graphics peripheral's sprite attribute table (OAM, 0xFE00–0xFE9F). A CPU write of a page number to the DMA register (0xFF46) triggers it. It then masters the data bus and copies 160 bytes from `{page, 8'h00}` into OAM, one read plus one write per byte. While active it asserts `busy` so the CPU bus arbiter stalls the CPU.

## Interface
Parameters:
- `OAM_BASE`, 16'hFE00, destination base address
- `XFER_LEN`, 160, bytes per transfer
- `DMA_REG_ADDR`, 16'hFF46, address of the trigger/readback register

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `s_wr`  in  1  CPU write strobe, qualified by `s_addr == DMA_REG_ADDR`
- `s_rd`  in  1  CPU read strobe, same qualification
- `s_addr`  in  16  CPU address
- `s_wdata`  in  8  CPU write data
- `s_rdata`  out  8  last written page; 0 outside a selected read
- `m_req`  out  1  bus request, held until granted
- `m_we`  out  1  1 = write, 0 = read; stable while `m_req`
- `m_addr`  out  16  master address; stable while `m_req`
- `m_wdata`  out  8  write data; stable while `m_req`
- `m_gnt`  in  1  arbiter grant; completes the access in the cycle it is high together with `m_req`
- `m_rdata`  in  8  read data, valid the cycle after a read grant
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse after the last OAM write is granted

## Operation
- Registers: `page_q[7:0]`, `idx_q[7:0]` (0..159), `data_q[7:0]`, state.
- Source page: if `page_q >= 8'hE0`, use `page_q - 8'h20` (echo RAM); source address = `{src_page, idx_q}`. Destination = `OAM_BASE + idx_q`.
- FSM:
  - IDLE: `busy=0`. On a selected `s_wr`: `page_q <= s_wdata`, `idx_q <= 0`, go to RD.
  - RD: `m_req=1`, `m_we=0`. On `m_gnt`, go to CAP.
  - CAP: `data_q <= m_rdata`; go to WR. No request is driven.
  - WR: `m_req=1`, `m_we=1`, `m_wdata=data_q`. On `m_gnt`: if `idx_q == XFER_LEN-1`, go to IDLE and pulse `done`; else `idx_q++` and go to RD.
- `busy` = state != IDLE.
- Selected `s_rd`: `s_rdata = page_q`. The read is combinational and is also valid while busy.
- Writes to `DMA_REG_ADDR` while busy: handled per Configuration.
- A simultaneous `s_wr` and `s_rd` in IDLE: the write wins, and `s_rdata` shows the old `page_q`.

## Timing
- Reset (async assert, sync release) sets: state=IDLE, `page_q=0`, `idx_q=0`, `data_q=0`, `m_req=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`, `busy=0`, `done=0`.
- Trigger to first `m_req`: 1 cycle; `busy` rises on the same edge.
- With `m_gnt` tied high, each byte takes 3 cycles (RD, CAP, WR). A full transfer is 480 cycles from the first `m_req` to the `done` pulse, and `busy` falls on the same edge as `done`.
- When the grant is withheld, the FSM holds its state and outputs stable, with no timeout.
- Reset mid-transfer aborts immediately. No further bus requests are made and OAM is left partially written.
- `idx_q` never exceeds `XFER_LEN-1`; with the default it stays in 8 bits and no wrap is possible.

## Configuration
- `OAM_DMA_RESTART_EN` defined: a selected `s_wr` while busy loads the new page, clears `idx_q`, and goes to RD on the next edge. An in-flight granted access still completes that cycle. No `done` pulse is generated for the aborted transfer.
- Not defined: a selected `s_wr` while busy is ignored entirely, including `page_q`.

## Structure
- The shared video/memory package holds `OAM_LOC` (0xFE00), `OAM_SIZE` (160), `DMA_REG_ADDR` (0xFF46), and the enum `dma_state_t {DMA_IDLE, DMA_RD, DMA_CAP, DMA_WR}`.
- Single module, no sub-modules. The source-address echo remap is a local function.

## Test plan
- Write 8'hC1 to 0xFF46 with `m_gnt=1` and memory[C100+i]=i^8'h5A → 160 writes to FE00+i with data i^8'h5A. `done` pulses exactly once, 480 cycles after the first `m_req`, and 0xFF46 reads back 8'hC1.
- Page 8'hE3 → reads are issued to C300..C39F.
- Grant withheld randomly (e.g. 3 of 4 cycles low) → `m_addr`/`m_we`/`m_wdata` stay stable while ungranted. Data is correct and the byte count is 160.
- Second write of 8'hD0 at byte 50:
  - With `OAM_DMA_RESTART_EN`: the next read is D000 and one `done` occurs after 160 further bytes.
  - Without: the write is ignored, the transfer completes from C1xx, and the readback is C1.
- `reset_n` low at byte 80 → all outputs return to reset values asynchronously, with no `m_req` after release. A fresh trigger then completes normally.
- Read 0xFF46 after reset → 8'h00; an unselected address → `s_rdata`=0.
